// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_unit
// Purpose  : Program counter, instruction register, combinational decode of
//            the latched 16-bit instruction and the memory address mux.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       data_bus,
    input  logic              PC_L,
    input  logic              PC_I,
    input  logic              IR_L,
    input  logic              mem_addr_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       ir,
    output logic [4:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        rs1,
    output logic [2:0]        rs2,
    output logic [ADDR_W-1:0] addr_field,
    output logic              is_arithmetic,
    output logic              is_immediate,
    output logic              is_load,
    output logic              is_store,
    output logic              is_jump_unconditional,
    output logic              is_jump_conditional,
    output logic              illegal
);

    localparam logic [4:0] c_OP_NOP   = 5'b00000;
    localparam logic [4:0] c_OP_LOAD  = 5'b00100;
    localparam logic [4:0] c_OP_STORE = 5'b00101;
    localparam logic [4:0] c_OP_ADD   = 5'b01000;
    localparam logic [4:0] c_OP_SUB   = 5'b01001;
    localparam logic [4:0] c_OP_INCR  = 5'b01100;
    localparam logic [4:0] c_OP_DECR  = 5'b01101;
    localparam logic [4:0] c_OP_SHL   = 5'b01110;
    localparam logic [4:0] c_OP_RRC   = 5'b01111;
    localparam logic [4:0] c_OP_JMP   = 5'b10000;
    localparam logic [4:0] c_OP_JNC   = 5'b10100;
    localparam logic [4:0] c_OP_JZ    = 5'b10101;
    localparam logic [4:0] c_OP_JNZ   = 5'b10110;
    localparam logic [4:0] c_OP_JC    = 5'b10111;

    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [4:0]        w_opcode;
    logic [ADDR_W-1:0] w_addr_field;

    assign w_opcode     = r_ir[15:11];
    assign w_addr_field = r_ir[ADDR_W-1:0];

    // PC_L uses the address field of the IR as it stands before this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (PC_L) begin
            r_pc <= w_addr_field;
        end else if (PC_I) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir <= 16'h0000;
        end else if (IR_L) begin
            r_ir <= data_bus;
        end
    end

    always_comb begin
        rd                    = 3'd0;
        rs1                   = 3'd0;
        rs2                   = 3'd0;
        is_arithmetic         = 1'b0;
        is_immediate          = 1'b0;
        is_load               = 1'b0;
        is_store              = 1'b0;
        is_jump_unconditional = 1'b0;
        is_jump_conditional   = 1'b0;
        illegal               = 1'b0;
        case (w_opcode)
            c_OP_NOP: ;
            c_OP_ADD, c_OP_SUB: begin
                rd            = r_ir[10:8];
                rs1           = r_ir[7:5];
                rs2           = r_ir[4:2];
                is_arithmetic = 1'b1;
            end
            c_OP_INCR, c_OP_DECR, c_OP_SHL, c_OP_RRC: begin
                rd           = r_ir[10:8];
                is_immediate = 1'b1;
            end
            c_OP_LOAD: begin
                rd      = r_ir[10:8];
                is_load = 1'b1;
            end
            // the store source register travels on the rs2 read port
            c_OP_STORE: begin
                rs2      = r_ir[10:8];
                is_store = 1'b1;
            end
            c_OP_JMP: is_jump_unconditional = 1'b1;
            c_OP_JNC, c_OP_JZ, c_OP_JNZ, c_OP_JC: is_jump_conditional = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign mem_addr   = mem_addr_sel ? w_addr_field : r_pc;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign opcode     = w_opcode;
    assign addr_field = w_addr_field;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_unit
// Purpose  : Scoreboard bench for fetch_decode_unit (ADDR_W=8, RESET_PC=8'h10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_unit;

    localparam int         ADDR_W   = 8;
    localparam logic [7:0] RESET_PC = 8'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data_bus = '0;
    logic        PC_L = 1'b0, PC_I = 1'b0, IR_L = 1'b0, mem_addr_sel = 1'b0;
    logic [7:0]  mem_addr, pc, addr_field;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic [2:0]  rd, rs1, rs2;
    logic        is_arithmetic, is_immediate, is_load, is_store;
    logic        is_jump_unconditional, is_jump_conditional, illegal;

    fetch_decode_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .data_bus(data_bus),
        .PC_L(PC_L), .PC_I(PC_I), .IR_L(IR_L), .mem_addr_sel(mem_addr_sel),
        .mem_addr(mem_addr), .pc(pc), .ir(ir), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .addr_field(addr_field),
        .is_arithmetic(is_arithmetic), .is_immediate(is_immediate),
        .is_load(is_load), .is_store(is_store),
        .is_jump_unconditional(is_jump_unconditional),
        .is_jump_conditional(is_jump_conditional), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ir;
        logic [7:0]  mem_addr;
        logic [2:0]  rd, rs1, rs2;
        logic [5:0]  flags;   // arith, imm, load, store, jmp, jcc
        logic        illegal;
    } exp_t;

    exp_t       r_sb[$];
    int         r_errors = 0;
    int         r_checks = 0;
    logic [7:0]  r_mpc = '0;
    logic [15:0] r_mir = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t decode_model(input logic [15:0] w, input logic [7:0] p, input logic sel);
        exp_t e;
        e.pc = p; e.ir = w; e.mem_addr = sel ? w[7:0] : p;
        e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.flags = 0; e.illegal = 0;
        case (w[15:11])
            5'd0:  ;
            5'd8, 5'd9: begin e.rd = w[10:8]; e.rs1 = w[7:5]; e.rs2 = w[4:2]; e.flags = 6'b100000; end
            5'd12, 5'd13, 5'd14, 5'd15: begin e.rd = w[10:8]; e.flags = 6'b010000; end
            5'd4:  begin e.rd = w[10:8]; e.flags = 6'b001000; end
            5'd5:  begin e.rs2 = w[10:8]; e.flags = 6'b000100; end
            5'd16: e.flags = 6'b000010;
            5'd20, 5'd21, 5'd22, 5'd23: e.flags = 6'b000001;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Drive one cycle of stimulus, predict its result, then compare after the edge
    task automatic step(input logic rst, input logic [15:0] d, input logic pcl,
                        input logic pci, input logic irl, input logic sel);
        exp_t e;
        reset = rst; data_bus = d; PC_L = pcl; PC_I = pci; IR_L = irl; mem_addr_sel = sel;
        if (rst) begin
            r_mpc = RESET_PC; r_mir = 16'h0000;
        end else begin
            if (pcl)      r_mpc = r_mir[7:0];
            else if (pci) r_mpc = r_mpc + 8'd1;
            if (irl)      r_mir = d;
        end
        r_sb.push_back(decode_model(r_mir, r_mpc, sel));
        @(posedge clk);
        #1;
        reset = 1'b0; PC_L = 1'b0; PC_I = 1'b0; IR_L = 1'b0;
        if (r_sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = r_sb.pop_front();
            check("pc", pc, e.pc);
            check("ir", ir, e.ir);
            check("opcode", opcode, e.ir[15:11]);
            check("addr_field", addr_field, e.ir[7:0]);
            check("mem_addr", mem_addr, e.mem_addr);
            check("rd", rd, e.rd);
            check("rs1", rs1, e.rs1);
            check("rs2", rs2, e.rs2);
            check("flags", {is_arithmetic, is_immediate, is_load, is_store,
                            is_jump_unconditional, is_jump_conditional}, e.flags);
            check("illegal", illegal, e.illegal);
        end
    endtask

    initial begin
        // reset and basic fetch of ADD r2,r2,r5
        step(1, 16'h0000, 0, 0, 0, 0);
        step(1, 16'h0000, 0, 0, 0, 0);
        step(0, 16'h4254, 0, 1, 1, 0);
        // STORE r3,[3C] with both address mux settings
        step(0, 16'h2B3C, 0, 0, 1, 1);
        step(0, 16'h0000, 0, 0, 0, 0);
        // JMP 77 fetched, then PC_L wins over PC_I
        step(0, 16'h8077, 0, 1, 1, 0);
        step(0, 16'h0000, 1, 1, 0, 0);
        // PC_L samples the old IR while IR_L loads a new one
        step(0, 16'h80FF, 1, 0, 1, 1);
        step(0, 16'h0000, 1, 0, 0, 0);
        // wrap FF -> 00
        step(0, 16'h0000, 0, 1, 0, 0);
        step(0, 16'hF800, 0, 1, 1, 0);
        // every opcode with random operand bits and strobes
        for (int op = 0; op < 32; op++) begin
            logic [15:0] w;
            w = {op[4:0], 11'($urandom)};
            step(0, w, 1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            step(0, 16'($urandom), 0, 1'($urandom), 1'b0, 1'($urandom));
        end
        // reset beats simultaneous strobes
        step(0, 16'h4254, 0, 1, 1, 0);
        step(1, 16'h2B3C, 1, 1, 1, 1);
        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
